// File: rtl/booth_datapath_if.sv
// rtl/booth_datapath_if.sv - controller-to-datapath bus for the radix-2 Booth multiplier
//
// Purpose : bundles the controller strobes, operands and datapath status/result
//           so the controller (master) and the datapath (slave) share one port.
// Signals : clear        - load / abort strobe (controller rst_out)
//           en_inp       - input-mux enable (controller enInp)
//           en_p         - iteration strobe (controller enP)
//           multiplicand - signed operand A, WIDTH bits
//           multiplier   - signed operand B, WIDTH bits
//           counter      - completed iteration count, COUNTER_SIZE bits
//           product      - signed product {P,Q}, 2*WIDTH bits
//           done         - high while counter == WIDTH
interface booth_datapath_if #(
   parameter int WIDTH        = 6,
   parameter int COUNTER_SIZE = 4
) ();
   logic                    clear;
   logic                    en_inp;
   logic                    en_p;
   logic [WIDTH-1:0]        multiplicand;
   logic [WIDTH-1:0]        multiplier;
   logic [COUNTER_SIZE-1:0] counter;
   logic [2*WIDTH-1:0]      product;
   logic                    done;

   modport master (
      output clear, en_inp, en_p, multiplicand, multiplier,
      input  counter, product, done
   );

   modport slave (
      input  clear, en_inp, en_p, multiplicand, multiplier,
      output counter, product, done
   );
endinterface

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - radix-2 Booth multiplier datapath with IDLE/RUN phase
//
// Purpose : holds M, P, Q, q_m1 and the iteration counter; performs one Booth
//           step per qualified en_p while in RUN and below WIDTH iterations.
// Ports   : clk    - rising-edge clock
//           rst_in - asynchronous active-low reset
//           bus    - booth_datapath_if.slave (strobes, operands, counter,
//                    product, done)
module booth_datapath #(
   parameter int WIDTH        = 6,
   parameter int COUNTER_SIZE = 4
) (
   input  logic              clk,
   input  logic              rst_in,
   booth_datapath_if.slave   bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} phase_t;

   localparam logic [COUNTER_SIZE-1:0] WIDTH_C = COUNTER_SIZE'(WIDTH);
   localparam logic [COUNTER_SIZE-1:0] ONE_C   = COUNTER_SIZE'(1);

   phase_t                  phase_q, phase_d;
   logic [WIDTH-1:0]        m_q, m_d;
   logic [WIDTH-1:0]        p_q, p_d;
   logic [WIDTH-1:0]        q_q, q_d;
   logic                    qm1_q, qm1_d;
   logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
   logic                    done_q, done_d;

   // One extra bit keeps P +/- M exact for the most negative operand; its MSB
   // becomes the shifted-in sign of P.
   logic [WIDTH:0]          p_ext, m_ext, t_w;

   assign p_ext = {p_q[WIDTH-1], p_q};
   assign m_ext = {m_q[WIDTH-1], m_q};

   always_comb begin
      t_w = p_ext;
      case ({q_q[0], qm1_q})
         2'b01:   t_w = p_ext + m_ext;
         2'b10:   t_w = p_ext - m_ext;
         default: t_w = p_ext;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      m_d     = m_q;
      p_d     = p_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;

      if (bus.clear) begin
         // clear wins over en_p; with en_inp it loads, otherwise it aborts.
         p_d   = '0;
         qm1_d = 1'b0;
         cnt_d = '0;
         if (bus.en_inp) begin
            m_d     = bus.multiplicand;
            q_d     = bus.multiplier;
            phase_d = RUN;
         end else begin
            m_d     = '0;
            q_d     = '0;
            phase_d = IDLE;
         end
      end else if (bus.en_p && (phase_q == RUN) && (cnt_q < WIDTH_C)) begin
         p_d   = t_w[WIDTH:1];
         q_d   = {t_w[0], q_q[WIDTH-1:1]};
         qm1_d = q_q[0];
         cnt_d = cnt_q + ONE_C;
      end

      done_d = (cnt_d == WIDTH_C);
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         phase_q <= IDLE;
         m_q     <= '0;
         p_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         m_q     <= m_d;
         p_q     <= p_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.counter = cnt_q;
   assign bus.product = {p_q, q_q};
   assign bus.done    = done_q;

endmodule
